// File: rtl/latch_mem_arbiter.sv
// rtl/latch_mem_arbiter.sv - round-robin arbiter sharing one latch RAM port between requesters A and B
module latch_mem_arbiter #(
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [31:0]          a_data_in,
  input  logic [1:0]           a_data_write_n,
  input  logic [1:0]           a_data_read_n,
  output logic [31:0]          a_data_out,
  output logic                 a_data_ready,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [31:0]          b_data_in,
  input  logic [1:0]           b_data_write_n,
  input  logic [1:0]           b_data_read_n,
  output logic [31:0]          b_data_out,
  output logic                 b_data_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_data_in,
  output logic [1:0]           mem_data_write_n,
  output logic [1:0]           mem_data_read_n,
  input  logic [31:0]          mem_data_out,
  input  logic                 mem_data_ready,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_b_q, last_b_d;  // 1 when B was the most recent grant

  logic a_pend, b_pend, owner_a, owner_b, owner_pend, busy;

  assign a_pend     = (a_data_read_n & a_data_write_n) != 2'b11;
  assign b_pend     = (b_data_read_n & b_data_write_n) != 2'b11;
  assign busy       = (state_q == BUSY);
  assign owner_a    = (grant_q == 2'b01);
  assign owner_b    = (grant_q == 2'b10);
  assign owner_pend = (owner_a & a_pend) | (owner_b & b_pend);
  assign grant      = grant_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (a_pend || b_pend) begin
          state_d = BUSY;
          if (a_pend && (!b_pend || last_b_q)) begin
            grant_d  = 2'b01;
            last_b_d = 1'b0;
          end else begin
            grant_d  = 2'b10;
            last_b_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // an owner that withdrew its request ends the cycle exactly like a completion
        if (!owner_pend || mem_data_ready) begin
          state_d = RELEASE;
          grant_d = 2'b00;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_comb begin
    mem_addr         = '0;
    mem_data_in      = '0;
    mem_data_write_n = 2'b11;
    mem_data_read_n  = 2'b11;
    if (busy && owner_a) begin
      mem_addr         = a_addr;
      mem_data_in      = a_data_in;
      mem_data_write_n = a_data_write_n;
      mem_data_read_n  = a_data_read_n;
    end else if (busy && owner_b) begin
      mem_addr         = b_addr;
      mem_data_in      = b_data_in;
      mem_data_write_n = b_data_write_n;
      mem_data_read_n  = b_data_read_n;
    end
  end

  assign a_data_ready = busy & owner_a & a_pend & mem_data_ready;
  assign b_data_ready = busy & owner_b & b_pend & mem_data_ready;
  assign a_data_out   = a_data_ready ? mem_data_out : 32'd0;
  assign b_data_out   = b_data_ready ? mem_data_out : 32'd0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: tb/tb_latch_mem_arbiter.sv
// tb/tb_latch_mem_arbiter.sv - randomized bench with latch RAM model and transaction-level arbitration model
module tb_latch_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0, mem_addr;
  logic [31:0] a_data_in = '0, b_data_in = '0, a_data_out, b_data_out, mem_data_in;
  logic [1:0]  a_data_write_n = 2'b11, a_data_read_n = 2'b11;
  logic [1:0]  b_data_write_n = 2'b11, b_data_read_n = 2'b11;
  logic        a_data_ready, b_data_ready;
  logic [1:0]  mem_data_write_n, mem_data_read_n, grant;
  logic [31:0] mem_data_out = '0;
  logic        mem_data_ready = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] ram [32];
  logic [7:0] shadow [32];
  int ram_cnt = 0;
  int ram_lat = 2;
  bit model_last_b = 1'b1;

  typedef struct {
    bit         act;
    bit         wr;
    logic [1:0] w;
    logic [4:0] addr;
    logic [31:0] data;
  } req_t;
  req_t ra, rb;

  always #5 clk = ~clk;

  latch_mem_arbiter #(.ADDR_BITS(5)) dut (
    .clk(clk), .rstn(rstn),
    .a_addr(a_addr), .a_data_in(a_data_in), .a_data_write_n(a_data_write_n),
    .a_data_read_n(a_data_read_n), .a_data_out(a_data_out), .a_data_ready(a_data_ready),
    .b_addr(b_addr), .b_data_in(b_data_in), .b_data_write_n(b_data_write_n),
    .b_data_read_n(b_data_read_n), .b_data_out(b_data_out), .b_data_ready(b_data_ready),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_write_n(mem_data_write_n),
    .mem_data_read_n(mem_data_read_n), .mem_data_out(mem_data_out),
    .mem_data_ready(mem_data_ready), .grant(grant)
  );

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] rd_bytes(input logic [4:0] addr, input logic [1:0] w, input bit from_shadow);
    logic [31:0] v;
    logic [4:0]  ad;
    v = '0;
    for (int i = 0; i < nbytes(w); i++) begin
      ad = addr + 5'(i);
      v[8*i +: 8] = from_shadow ? shadow[ad] : ram[ad];
    end
    return v;
  endfunction

  task automatic wr_bytes(input logic [4:0] addr, input logic [1:0] w, input logic [31:0] d, input bit to_shadow);
    logic [4:0] ad;
    for (int i = 0; i < nbytes(w); i++) begin
      ad = addr + 5'(i);
      if (to_shadow) shadow[ad] = d[8*i +: 8];
      else ram[ad] = d[8*i +: 8];
    end
  endtask

  task automatic ram_eval();
    if (mem_data_read_n != 2'b11 || mem_data_write_n != 2'b11) begin
      ram_cnt++;
      if (ram_cnt >= ram_lat) begin
        mem_data_ready = 1'b1;
        mem_data_out = (mem_data_read_n != 2'b11) ? rd_bytes(mem_addr, mem_data_read_n, 1'b0) : 32'd0;
      end else begin
        mem_data_ready = 1'b0;
        mem_data_out = $urandom;
      end
    end else begin
      ram_cnt = 0;
      mem_data_ready = 1'b0;
      mem_data_out = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ram_eval();
    #1;
    if (mem_data_ready && mem_data_write_n != 2'b11 && (a_data_ready || b_data_ready))
      wr_bytes(mem_addr, mem_data_write_n, mem_data_in, 1'b0);
  endtask

  task automatic drive_a();
    a_addr = ra.addr;
    a_data_in = ra.data;
    a_data_write_n = (ra.act && ra.wr) ? ra.w : 2'b11;
    a_data_read_n = (ra.act && !ra.wr) ? ra.w : 2'b11;
  endtask

  task automatic drive_b();
    b_addr = rb.addr;
    b_data_in = rb.data;
    b_data_write_n = (rb.act && rb.wr) ? rb.w : 2'b11;
    b_data_read_n = (rb.act && !rb.wr) ? rb.w : 2'b11;
  endtask

  task automatic rand_req(output req_t r, input bit act);
    r.act = act;
    r.wr = 1'($urandom_range(0, 1));
    r.w = 2'($urandom_range(0, 2));
    r.addr = 5'($urandom);
    r.data = $urandom;
  endtask

  task automatic model_op(input bit is_b, output logic [31:0] e);
    req_t r;
    r = is_b ? rb : ra;
    e = 32'd0;
    if (r.wr) wr_bytes(r.addr, r.w, r.data, 1'b1);
    else e = rd_bytes(r.addr, r.w, 1'b1);
  endtask

  // One arbitration round: requesters raise ra/rb together, each drops on its own ready pulse
  task automatic do_round(input string tag);
    bit a0, b0, first_b_exp, first_seen, first_b;
    int na, nb, cyc;
    logic [31:0] da, db, ea, eb;
    a0 = ra.act; b0 = rb.act;
    na = 0; nb = 0; cyc = 0; first_seen = 0; first_b = 0; da = 0; db = 0; ea = 0; eb = 0;
    first_b_exp = (a0 && b0) ? !model_last_b : b0;
    if (first_b_exp) begin
      model_op(1'b1, eb);
      if (a0) model_op(1'b0, ea);
    end else begin
      if (a0) model_op(1'b0, ea);
      if (b0) model_op(1'b1, eb);
    end
    model_last_b = (a0 && b0) ? !first_b_exp : b0;
    drive_a(); drive_b();
    while (((ra.act && na == 0) || (rb.act && nb == 0)) && cyc < 60) begin
      tick();
      cyc++;
      if (a_data_ready) begin
        na++; da = a_data_out;
        if (!first_seen) begin first_seen = 1; first_b = 0; end
        ra.act = 0; drive_a();
      end
      if (b_data_ready) begin
        nb++; db = b_data_out;
        if (!first_seen) begin first_seen = 1; first_b = 1; end
        rb.act = 0; drive_b();
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      if (a_data_ready) na++;
      if (b_data_ready) nb++;
    end
    n_total++;
    if (cyc >= 60) $display("FAIL %s timeout: cycles %0d limit 60", tag, cyc);
    else n_pass++;
    n_total++;
    if (na !== int'(a0)) $display("FAIL %s a_ready_count: got %0d want %0d", tag, na, a0);
    else n_pass++;
    n_total++;
    if (nb !== int'(b0)) $display("FAIL %s b_ready_count: got %0d want %0d", tag, nb, b0);
    else n_pass++;
    if (a0 && b0) begin
      n_total++;
      if (first_b !== first_b_exp) $display("FAIL %s first_is_b: got %0d want %0d", tag, first_b, first_b_exp);
      else n_pass++;
    end
    if (a0) begin
      n_total++;
      if (da !== ea) $display("FAIL %s a_data_out: got %h want %h", tag, da, ea);
      else n_pass++;
    end
    if (b0) begin
      n_total++;
      if (db !== eb) $display("FAIL %s b_data_out: got %h want %h", tag, db, eb);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rand_req(ra, 1'b1); ra.wr = 0; drive_a();
    rand_req(rb, 1'b0); drive_b();
    tick(); tick();
    n_total++;
    if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant);
    else n_pass++;
    n_total++;
    if ({a_data_ready, b_data_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {a_data_ready, b_data_ready});
    else n_pass++;
    n_total++;
    if ({a_data_out, b_data_out} !== 64'd0) $display("FAIL reset_data_out: got %h want 0", {a_data_out, b_data_out});
    else n_pass++;
    n_total++;
    if ({mem_data_read_n, mem_data_write_n, mem_addr, mem_data_in} !== {4'hF, 37'd0})
      $display("FAIL reset_mem: got rn=%b wn=%b addr=%h din=%h want 11 11 0 0", mem_data_read_n, mem_data_write_n, mem_addr, mem_data_in);
    else n_pass++;
    ra.act = 0; drive_a();
    rstn = 1'b1;
    model_last_b = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    ram[5] = 8'hA5; shadow[5] = 8'hA5; ram[6] = 8'h3C; shadow[6] = 8'h3C;
    ram_lat = 2;
    ra = '{act: 1, wr: 0, w: 2'b00, addr: 5'd5, data: 32'hFFFF_FFFF};
    drive_a();
    #1;
    n_total++;
    if ({mem_data_read_n, grant} !== 4'b1100) $display("FAIL c0_idle: got rn=%b grant=%b want 11 00", mem_data_read_n, grant);
    else n_pass++;
    tick();
    n_total++;
    if ({mem_data_read_n, grant, mem_addr, a_data_ready} !== {2'b00, 2'b01, 5'd5, 1'b0})
      $display("FAIL c1_busy: got rn=%b grant=%b addr=%0d rdy=%b want 00 01 5 0", mem_data_read_n, grant, mem_addr, a_data_ready);
    else n_pass++;
    tick();
    n_total++;
    if ({a_data_ready, a_data_out} !== {1'b1, 32'h0000_00A5})
      $display("FAIL c2_ready: got rdy=%b data=%h want 1 000000a5", a_data_ready, a_data_out);
    else n_pass++;
    ra.act = 0; drive_a();
    tick();
    n_total++;
    if ({grant, mem_data_read_n, mem_data_write_n, a_data_ready} !== {2'b00, 4'hF, 1'b0})
      $display("FAIL c3_release: got grant=%b rn=%b wn=%b rdy=%b want 00 11 11 0", grant, mem_data_read_n, mem_data_write_n, a_data_ready);
    else n_pass++;
    tick();
    model_last_b = 1'b0;
  endtask

  task automatic test_round_robin();
    rstn = 1'b0; tick(); rstn = 1'b1; model_last_b = 1'b1; tick();
    for (int r = 0; r < 5; r++) begin
      ram_lat = $urandom_range(1, 3);
      rand_req(ra, 1'b1); rand_req(rb, 1'b1);
      if (r == 2) rb.act = 0;
      do_round($sformatf("rr%0d", r));
    end
  endtask

  task automatic test_b_write();
    int na, nb, busy_cyc;
    bit bad;
    na = 0; nb = 0; busy_cyc = 0; bad = 0;
    ram_lat = 3;
    rb = '{act: 1, wr: 1, w: 2'b10, addr: 5'd8, data: 32'hDEAD_BEEF};
    drive_b();
    for (int i = 0; i < 12 && nb == 0; i++) begin
      tick();
      if (grant == 2'b10) begin
        busy_cyc++;
        if ({mem_data_write_n, mem_data_read_n, mem_addr, mem_data_in} !== {2'b10, 2'b11, 5'd8, 32'hDEAD_BEEF}) bad = 1;
      end
      if (a_data_ready) na++;
      if (b_data_ready) begin nb++; rb.act = 0; drive_b(); end
    end
    tick(); tick();
    if (a_data_ready) na++;
    if (b_data_ready) nb++;
    wr_bytes(5'd8, 2'b10, 32'hDEAD_BEEF, 1'b1);
    model_last_b = 1'b1;
    n_total++;
    if (bad) $display("FAIL bwr_mem_fields: got mismatching mem fields want wn=10 din=deadbeef addr=8");
    else n_pass++;
    n_total++;
    if (busy_cyc !== 3) $display("FAIL bwr_busy_cycles: got %0d want 3", busy_cyc);
    else n_pass++;
    n_total++;
    if ({na, nb} !== {32'd0, 32'd1}) $display("FAIL bwr_ready_counts: got a=%0d b=%0d want 0 1", na, nb);
    else n_pass++;
    ram_lat = 2;
    ra = '{act: 1, wr: 0, w: 2'b10, addr: 5'd8, data: 32'd0};
    rb.act = 0;
    do_round("bwr_readback");
  endtask

  task automatic test_abort();
    logic [31:0] eb;
    int nb;
    nb = 0;
    ram_lat = 8;
    rand_req(ra, 1'b1); ra.wr = 0; ra.w = 2'b01; drive_a();
    tick();
    n_total++;
    if (grant !== 2'b01) $display("FAIL abort_grant_a: got %b want 01", grant);
    else n_pass++;
    rand_req(rb, 1'b1); rb.wr = 0; drive_b();
    @(posedge clk);
    #1;
    ra.act = 0; drive_a();
    mem_data_ready = 1'b1; mem_data_out = 32'h1234_5679;
    #1;
    n_total++;
    if ({a_data_ready, b_data_ready, a_data_out, b_data_out} !== 66'd0)
      $display("FAIL abort_same_cycle: got ra=%b rb=%b oa=%h ob=%h want all 0", a_data_ready, b_data_ready, a_data_out, b_data_out);
    else n_pass++;
    tick();
    n_total++;
    if ({grant, mem_data_read_n, mem_data_write_n, a_data_ready} !== {2'b00, 4'hF, 1'b0})
      $display("FAIL abort_release: got grant=%b rn=%b wn=%b rdy=%b want 00 11 11 0", grant, mem_data_read_n, mem_data_write_n, a_data_ready);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (grant !== 2'b10) $display("FAIL abort_grant_b: got %b want 10", grant);
    else n_pass++;
    eb = rd_bytes(rb.addr, rb.w, 1'b1);
    for (int i = 0; i < 15 && nb == 0; i++) begin
      if (b_data_ready) begin
        nb++;
        n_total++;
        if (b_data_out !== eb) $display("FAIL abort_b_data: got %h want %h", b_data_out, eb);
        else n_pass++;
        rb.act = 0; drive_b();
      end else tick();
    end
    n_total++;
    if (nb !== 1) $display("FAIL abort_b_done: got %0d want 1", nb);
    else n_pass++;
    tick(); tick();
    model_last_b = 1'b1;
  endtask

  task automatic test_reset_busy();
    int nrdy;
    nrdy = 0;
    ram_lat = 8;
    rand_req(ra, 1'b1); ra.wr = 0; ra.w = 2'b01; drive_a();
    tick();
    n_total++;
    if (grant !== 2'b01) $display("FAIL rstbusy_grant: got %b want 01", grant);
    else n_pass++;
    rstn = 1'b0;
    tick();
    n_total++;
    if ({grant, a_data_ready, b_data_ready, mem_data_read_n, mem_data_write_n, a_data_out, b_data_out} !== {2'b00, 2'b00, 4'hF, 64'd0})
      $display("FAIL rstbusy_outputs: got grant=%b ra=%b rb=%b rn=%b wn=%b", grant, a_data_ready, b_data_ready, mem_data_read_n, mem_data_write_n);
    else n_pass++;
    ra.act = 0; drive_a();
    rstn = 1'b1;
    model_last_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_data_ready || b_data_ready) nrdy++;
    end
    n_total++;
    if (nrdy !== 0) $display("FAIL rstbusy_no_ready: got %0d pulses want 0", nrdy);
    else n_pass++;
  endtask

  task automatic test_random();
    int mask;
    for (int r = 0; r < 30; r++) begin
      mask = $urandom_range(1, 3);
      ram_lat = $urandom_range(1, 3);
      rand_req(ra, mask[0]); rand_req(rb, mask[1]);
      do_round($sformatf("rnd%0d", r));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i] = 8'($urandom);
      shadow[i] = ram[i];
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_b_write();
    test_abort();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/latch_mem_arbiter.md
LATCH_MEM_ARBITER -- requirements
Module: latch_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 5, giving the RAM byte-address width.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 a_addr  input  ADDR_BITS  requester A byte address.
REQ-005 a_data_in  input  32  requester A write data (bottom 8/16/32 bits valid).
REQ-006 a_data_write_n  input  2  requester A write: 11 none, 00 8-bit, 01 16-bit, 10 32-bit.
REQ-007 a_data_read_n  input  2  requester A read, same encoding.
REQ-008 a_data_out  output  32  requester A read data, valid while a_data_ready=1.
REQ-009 a_data_ready  output  1  requester A transaction complete, single-cycle pulse.
REQ-010 b_addr, b_data_in, b_data_write_n, b_data_read_n, b_data_out, b_data_ready SHALL mirror REQ-004..009 for requester B, one port per line in the RTL.
REQ-011 mem_addr  output  ADDR_BITS  address to the latch RAM.
REQ-012 mem_data_in  output  32  write data to the latch RAM.
REQ-013 mem_data_write_n  output  2  write request to the latch RAM.
REQ-014 mem_data_read_n  output  2  read request to the latch RAM.
REQ-015 mem_data_out  input  32  read data from the latch RAM.
REQ-016 mem_data_ready  input  1  completion from the latch RAM.
REQ-017 grant  output  2  current owner: 00 none, 01 A, 10 B.

Function
REQ-018 A port is pending when its data_read_n & data_write_n != 11; requesters SHALL hold request fields stable until their ready pulse.
REQ-019 FSM states SHALL be IDLE, BUSY, RELEASE; IDLE->BUSY when any port pending, BUSY->RELEASE on owner ready or abort, RELEASE->IDLE unconditionally.
REQ-020 In IDLE with one pending port, that port SHALL be granted at the next edge; with both pending, the port not granted last SHALL win (round-robin).
REQ-021 The last-grant pointer SHALL update only on entry to BUSY.
REQ-022 In BUSY, mem_addr/mem_data_in/mem_data_write_n/mem_data_read_n SHALL equal the owner's inputs combinationally.
REQ-023 In IDLE and RELEASE, mem_data_write_n and mem_data_read_n SHALL be 11, mem_addr 0, mem_data_in 0.
REQ-024 Owner data_ready SHALL equal mem_data_ready AND state BUSY AND owner request still pending; non-owner data_ready SHALL be 0.
REQ-025 Owner data_out SHALL equal mem_data_out while its ready is 1, else 0; non-owner data_out SHALL be 0.
REQ-026 If the owner's request becomes 11 in BUSY before mem_data_ready (abort), the FSM SHALL go to RELEASE with no ready pulse; mem_data_ready in that same cycle SHALL be dropped.
REQ-027 RELEASE SHALL present 11 to the RAM for exactly one cycle so its byte-cycle counter clears before the next grant.
REQ-028 A request still pending after its ready pulse SHALL be treated as a new request in IDLE.
REQ-029 Minimum turnaround SHALL be request visible in IDLE cycle N -> RAM request from N+1 -> IDLE again two cycles after the ready cycle.
REQ-030 A port not granted SHALL wait with no ready pulse and unchanged outputs; arbitration SHALL not depend on access width.

Reset
REQ-031 With rstn=0 at an edge: state IDLE, grant 00, last-grant pointer B (A wins first tie), all ready outputs 0, all data_out 0, mem read/write 11.
REQ-032 Reset asserted in BUSY SHALL abandon the transaction with no ready pulse; rstn=1 resumes in IDLE at the next edge.

Verification
REQ-033 Only A 8-bit read addr 5, model ready 2 cycles after request -> mem_data_read_n=00 from cycle 1, a_data_ready pulse at cycle 2, grant 01 then 00.
REQ-034 A and B both pending out of reset -> A granted first, B second; repeated ties alternate A,B,A,B.
REQ-035 B 32-bit write 0xDEADBEEF to addr 8 -> mem_data_write_n=10, mem_data_in=0xDEADBEEF throughout BUSY, b_data_ready once, a_data_ready 0.
REQ-036 A drops request mid-BUSY -> no a_data_ready, one RELEASE cycle with mem read/write 11, then B granted if pending.
REQ-037 rstn low during BUSY on a 16-bit read -> outputs per REQ-031 next cycle, no ready pulse on either port.
